// File: rtl/lsb_mem_queue_if.sv
// Memory-controller handshake for the load/store queue: request fields held until mem_done.
interface lsb_mem_queue_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_len;
    logic        mem_done;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_len,
        input  mem_done, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_len,
        output mem_done, mem_rdata
    );
endinterface

// File: rtl/lsb_mem_queue.sv
// In-order load/store queue between dispatch, the ROB and the memory controller.
// Optional LSB_MMIO_EN: loads to IO space (addr[17:16]==2'b11) wait until they are at the ROB head.
module lsb_mem_queue #(
    parameter int unsigned LSB_SZ    = 16,
    parameter int unsigned ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [ROB_IDX_W-1:0] in_rob_id,
    input  logic                 in_is_store,
    input  logic [1:0]           in_len,
    input  logic                 in_signed,
    input  logic [ROB_IDX_W-1:0] in_q1,
    input  logic [ROB_IDX_W-1:0] in_q2,
    input  logic [31:0]          in_v1,
    input  logic [31:0]          in_v2,
    input  logic [31:0]          in_imm,
    output logic                 full,
    input  logic                 alu_valid,
    input  logic [ROB_IDX_W-1:0] alu_rd,
    input  logic [31:0]          alu_res,
    input  logic [ROB_IDX_W-1:0] rob_head,
    input  logic                 str_commit,
    output logic                 str_rdy_valid,
    output logic [ROB_IDX_W-1:0] str_rdy_rd,
    output logic                 lad_valid,
    output logic [ROB_IDX_W-1:0] lad_rd,
    output logic [31:0]          lad_res,
    output logic                 mem_commit,
    lsb_mem_queue_if.master      mem
);

    localparam int unsigned PTR_W   = $clog2(LSB_SZ);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned FULL_AT = LSB_SZ - 1;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] q;
        logic [31:0]          v;
    } opnd_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_id;
        logic                 is_store;
        logic [1:0]           len;
        logic                 sgn;
        opnd_t                b;
        opnd_t                d;
        logic [31:0]          imm;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_WAIT   = 3'd1,
        ST_ANN    = 3'd2,
        ST_WAIT_C = 3'd3,
        ST_WAIT_M = 3'd4,
        DRAIN     = 3'd5
    } state_t;

    entry_t             ent [LSB_SZ];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    state_t             state;

    entry_t             hd_c;
    entry_t             new_c;
    logic [31:0]        hd_addr_c;
    logic               ld_ok_c;
    logic               push_c;
    logic               pop_c;
    logic [CNT_W-1:0]   cnt_nxt_c;

    // Operand capture from the ALU or load result bus; tag 0 already holds a value.
    function automatic opnd_t snoop(
        input opnd_t                o,
        input logic                 av,
        input logic [ROB_IDX_W-1:0] ar,
        input logic [31:0]          ares,
        input logic                 lv,
        input logic [ROB_IDX_W-1:0] lr,
        input logic [31:0]          lres
    );
        opnd_t r;
        r = o;
        if (o.q != '0) begin
            if (av && (ar == o.q)) begin
                r.q = '0;
                r.v = ares;
            end else if (lv && (lr == o.q)) begin
                r.q = '0;
                r.v = lres;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] load_ext(
        input logic [31:0] r,
        input logic [1:0]  len,
        input logic        sgn
    );
        logic [31:0] x;
        case (len)
            2'd0:    x = sgn ? {{24{r[7]}}, r[7:0]}   : {24'd0, r[7:0]};
            2'd1:    x = sgn ? {{16{r[15]}}, r[15:0]} : {16'd0, r[15:0]};
            default: x = r;
        endcase
        return x;
    endfunction

    assign hd_c      = ent[head];
    assign hd_addr_c = hd_c.b.v + hd_c.imm;

`ifdef LSB_MMIO_EN
    assign ld_ok_c = (hd_addr_c[17:16] != 2'b11) || (hd_c.rob_id == rob_head);
`else
    logic unused_rob_head;
    assign ld_ok_c         = 1'b1;
    assign unused_rob_head = ^rob_head;
`endif

    // Incoming entry, with same-cycle broadcast forwarding.
    always_comb begin
        new_c          = '0;
        new_c.rob_id   = in_rob_id;
        new_c.is_store = in_is_store;
        new_c.len      = in_len;
        new_c.sgn      = in_signed;
        new_c.imm      = in_imm;
        new_c.b        = snoop('{q: in_q1, v: in_v1}, alu_valid, alu_rd, alu_res,
                               lad_valid, lad_rd, lad_res);
        new_c.d        = snoop('{q: in_q2, v: in_v2}, alu_valid, alu_rd, alu_res,
                               lad_valid, lad_rd, lad_res);
    end

    assign push_c    = in_valid && !flush && (count < CNT_W'(FULL_AT));
    assign pop_c     = mem.mem_done && !flush && ((state == LD_WAIT) || (state == ST_WAIT_M));
    assign cnt_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LSB_SZ); i++) ent[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < int'(LSB_SZ); i++) ent[i] <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
                full  <= 1'b0;
            end else begin
                for (int i = 0; i < int'(LSB_SZ); i++) begin
                    ent[i].b <= snoop(ent[i].b, alu_valid, alu_rd, alu_res,
                                      lad_valid, lad_rd, lad_res);
                    ent[i].d <= snoop(ent[i].d, alu_valid, alu_rd, alu_res,
                                      lad_valid, lad_rd, lad_res);
                end
                if (push_c) begin
                    ent[tail] <= new_c;
                    tail      <= tail + PTR_W'(1);
                end
                if (pop_c) head <= head + PTR_W'(1);
                count <= cnt_nxt_c;
                full  <= (cnt_nxt_c >= CNT_W'(FULL_AT));
            end
        end
    end

    // Head-entry sequencer; every output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            str_rdy_valid <= 1'b0;
            str_rdy_rd    <= '0;
            lad_valid     <= 1'b0;
            lad_rd        <= '0;
            lad_res       <= '0;
            mem_commit    <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_len   <= '0;
        end else if (rdy) begin
            str_rdy_valid <= 1'b0;
            lad_valid     <= 1'b0;
            mem_commit    <= 1'b0;
            if (flush) begin
                // An outstanding access must still finish; its result is dropped.
                if (((state == LD_WAIT) || (state == ST_WAIT_M) || (state == DRAIN)) && !mem.mem_done) begin
                    state <= DRAIN;
                end else begin
                    state       <= IDLE;
                    mem.mem_req <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (count != '0) begin
                            if (!hd_c.is_store) begin
                                if ((hd_c.b.q == '0) && ld_ok_c) begin
                                    mem.mem_req  <= 1'b1;
                                    mem.mem_we   <= 1'b0;
                                    mem.mem_addr <= hd_addr_c;
                                    mem.mem_len  <= hd_c.len;
                                    state        <= LD_WAIT;
                                end
                            end else if ((hd_c.b.q == '0) && (hd_c.d.q == '0)) begin
                                str_rdy_valid <= 1'b1;
                                str_rdy_rd    <= hd_c.rob_id;
                                state         <= ST_WAIT_C;
                            end
                        end
                    end
                    LD_WAIT: begin
                        if (mem.mem_done) begin
                            mem.mem_req <= 1'b0;
                            lad_valid   <= 1'b1;
                            lad_rd      <= hd_c.rob_id;
                            lad_res     <= load_ext(mem.mem_rdata, hd_c.len, hd_c.sgn);
                            state       <= IDLE;
                        end
                    end
                    ST_ANN, ST_WAIT_C: begin
                        if (str_commit) begin
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= 1'b1;
                            mem.mem_addr  <= hd_addr_c;
                            mem.mem_wdata <= hd_c.d.v;
                            mem.mem_len   <= hd_c.len;
                            state         <= ST_WAIT_M;
                        end
                    end
                    ST_WAIT_M: begin
                        if (mem.mem_done) begin
                            mem.mem_req <= 1'b0;
                            mem_commit  <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (mem.mem_done) begin
                            mem.mem_req <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
